// File: rtl/me_window_feeder.sv
// me_window_feeder: streams the current macroblock and the search window to
// the motion-estimation array as tagged column slices. Reads are issued only
// when the two-entry output FIFO is guaranteed to have room for the returning
// data, so the one-cycle read latency never causes overflow or lost words.
module me_window_feeder #(
   parameter int  MACRO_DIM  = 16,
   parameter int  SEARCH_DIM = 48,
   localparam int PORT_WIDTH = MACRO_DIM + 1,
   localparam int BANDS      = SEARCH_DIM - PORT_WIDTH + 1,
   localparam int CA_W       = $clog2(MACRO_DIM),
   localparam int SA_W       = $clog2(SEARCH_DIM),
   localparam int BW         = $clog2(BANDS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      cur_rd_en,
   output logic [CA_W-1:0]           cur_rd_addr,
   input  logic [MACRO_DIM*8-1:0]    cur_rd_data,
   output logic                      srch_rd_en,
   output logic [SA_W-1:0]           srch_rd_addr,
   input  logic [SEARCH_DIM*8-1:0]   srch_rd_data,
   output logic                      cpr_valid,
   input  logic                      cpr_ready,
   output logic [MACRO_DIM*8-1:0]    pixel_cpr_out,
   output logic                      spr_valid,
   input  logic                      spr_ready,
   output logic [PORT_WIDTH*8-1:0]   pixel_spr_out,
   output logic [BW-1:0]             spr_band,
   output logic [SA_W-1:0]           spr_col,
   output logic                      spr_last
);

   localparam int DW  = PORT_WIDTH * 8;
   localparam int PAD = DW - MACRO_DIM * 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // read sequencer position: phase (current/search), band and column
   logic            r_rd_srch;
   logic [BW-1:0]   r_rd_band;
   logic [SA_W-1:0] r_rd_col;

   // read issued last cycle whose data is on the bus this cycle
   logic            r_inf_valid;
   logic            r_inf_srch;
   logic [BW-1:0]   r_inf_band;
   logic [SA_W-1:0] r_inf_col;

   // two-entry tagged FIFO
   logic            r_fifo_srch [2];
   logic [BW-1:0]   r_fifo_band [2];
   logic [SA_W-1:0] r_fifo_col  [2];
   logic [DW-1:0]   r_fifo_data [2];
   logic            r_wr_ptr;
   logic            r_rd_ptr;
   logic [1:0]      r_count;

   logic            w_issue;
   logic            w_last_issue;
   logic            w_pop;
   logic            w_head_valid;
   logic            w_head_srch;
   logic [2:0]      w_occ_after;
   logic [1:0]      w_count_next;
   logic [DW-1:0]   w_slice;
   logic [DW-1:0]   w_cap_data;

   // room check counts the entry leaving this cycle and the word arriving
   assign w_head_valid = (r_count != 2'd0);
   assign w_head_srch  = r_fifo_srch[r_rd_ptr];
   assign w_pop        = w_head_valid && (w_head_srch ? spr_ready : cpr_ready);
   assign w_occ_after  = {1'b0, r_count} + {2'b0, r_inf_valid} - {2'b0, w_pop};
   assign w_count_next = r_count + {1'b0, r_inf_valid} - {1'b0, w_pop};
   assign w_issue      = (r_state == S_FETCH) && (w_occ_after < 3'd2);
   assign w_last_issue = w_issue && r_rd_srch
                         && (r_rd_band == BW'(BANDS - 1))
                         && (r_rd_col == SA_W'(SEARCH_DIM - 1));

   // band-offset slice: element k is search row (band + k) of the returned column
   genvar gi;
   generate
      for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_slice
         logic [SA_W-1:0] w_row;
         assign w_row = SA_W'(r_inf_band) + SA_W'(gi);
         assign w_slice[8*gi +: 8] = srch_rd_data[8*w_row +: 8];
      end
   endgenerate

   assign w_cap_data = r_inf_srch ? w_slice : {{PAD{1'b0}}, cur_rd_data};

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next-state and status outputs
   always_comb begin
      w_state_next = r_state;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_FETCH;
         S_FETCH: if (w_last_issue) w_state_next = S_DRAIN;
         S_DRAIN: if (w_count_next == 2'd0) w_state_next = S_DONE;
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // read sequencer: current columns first, then every search column per band
   always_ff @(posedge clk) begin
      if (rst || (r_state == S_IDLE && start)) begin
         r_rd_srch <= 1'b0;
         r_rd_band <= '0;
         r_rd_col  <= '0;
      end else if (w_issue) begin
         if (!r_rd_srch) begin
            if (r_rd_col == SA_W'(MACRO_DIM - 1)) begin
               r_rd_srch <= 1'b1;
               r_rd_col  <= '0;
            end else begin
               r_rd_col <= r_rd_col + 1'b1;
            end
         end else if (r_rd_col == SA_W'(SEARCH_DIM - 1)) begin
            r_rd_col <= '0;
            if (r_rd_band != BW'(BANDS - 1)) r_rd_band <= r_rd_band + 1'b1;
         end else begin
            r_rd_col <= r_rd_col + 1'b1;
         end
      end
   end

   // in-flight tracking; reset discards any word still returning
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inf_valid <= 1'b0;
      end else begin
         r_inf_valid <= w_issue;
      end
      r_inf_srch <= r_rd_srch;
      r_inf_band <= r_rd_band;
      r_inf_col  <= r_rd_col;
   end

   // FIFO storage written when returning read data is captured
   always_ff @(posedge clk) begin
      if (r_inf_valid) begin
         r_fifo_srch[r_wr_ptr] <= r_inf_srch;
         r_fifo_band[r_wr_ptr] <= r_inf_band;
         r_fifo_col[r_wr_ptr]  <= r_inf_col;
         r_fifo_data[r_wr_ptr] <= w_cap_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (r_inf_valid) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= w_count_next;
      end
   end

   // head entry steers to the port matching its type; idle ports read as zero
   always_comb begin
      cpr_valid     = w_head_valid && !w_head_srch;
      spr_valid     = w_head_valid && w_head_srch;
      pixel_cpr_out = '0;
      pixel_spr_out = '0;
      spr_band      = '0;
      spr_col       = '0;
      spr_last      = 1'b0;
      cur_rd_en     = w_issue && !r_rd_srch;
      srch_rd_en    = w_issue && r_rd_srch;
      cur_rd_addr   = '0;
      srch_rd_addr  = '0;
      if (cpr_valid) pixel_cpr_out = r_fifo_data[r_rd_ptr][MACRO_DIM*8-1:0];
      if (spr_valid) begin
         pixel_spr_out = r_fifo_data[r_rd_ptr];
         spr_band      = r_fifo_band[r_rd_ptr];
         spr_col       = r_fifo_col[r_rd_ptr];
         spr_last      = (r_fifo_band[r_rd_ptr] == BW'(BANDS - 1))
                         && (r_fifo_col[r_rd_ptr] == SA_W'(SEARCH_DIM - 1));
      end
      if (cur_rd_en) cur_rd_addr = r_rd_col[CA_W-1:0];
      if (srch_rd_en) srch_rd_addr = r_rd_col;
   end

endmodule

// File: tb/tb_me_window_feeder.sv
// Directed bench for me_window_feeder: full passes under several ready
// patterns, scoreboarded against hand-derived buffer contents.
module tb_me_window_feeder;

   localparam int NXFER = 16 + 32 * 48;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         busy, done;
   logic         cur_rd_en;
   logic [3:0]   cur_rd_addr;
   logic [127:0] cur_rd_data = '0;
   logic         srch_rd_en;
   logic [5:0]   srch_rd_addr;
   logic [383:0] srch_rd_data = '0;
   logic         cpr_valid;
   logic         cpr_ready = 1'b1;
   logic [127:0] pixel_cpr_out;
   logic         spr_valid;
   logic         spr_ready = 1'b1;
   logic [135:0] pixel_spr_out;
   logic [4:0]   spr_band;
   logic [5:0]   spr_col;
   logic         spr_last;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int xfer_cnt, rd_cnt, done_cnt, done_cycle, last_cycle, first_cpr_cycle;
   bit h_cpr, h_spr;
   logic [127:0] sv_cpr;
   logic [135:0] sv_spr;
   logic [4:0]   sv_band;
   logic [5:0]   sv_col;

   me_window_feeder dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
      .srch_rd_en(srch_rd_en), .srch_rd_addr(srch_rd_addr), .srch_rd_data(srch_rd_data),
      .cpr_valid(cpr_valid), .cpr_ready(cpr_ready), .pixel_cpr_out(pixel_cpr_out),
      .spr_valid(spr_valid), .spr_ready(spr_ready), .pixel_spr_out(pixel_spr_out),
      .spr_band(spr_band), .spr_col(spr_col), .spr_last(spr_last)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] cur_word(input int c);
      logic [127:0] w;
      for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'(j * 16 + c);
      return w;
   endfunction

   function automatic logic [383:0] srch_word(input int c);
      logic [383:0] w;
      for (int r = 0; r < 48; r++) w[8*r +: 8] = 8'(r + c);
      return w;
   endfunction

   function automatic logic [135:0] exp_slice(input int v, input int c);
      logic [135:0] w;
      for (int k = 0; k < 17; k++) w[8*k +: 8] = 8'(v + k + c);
      return w;
   endfunction

   // buffer models with one-cycle read latency; garbage when not read
   always @(posedge clk) begin
      cur_rd_data  <= cur_rd_en ? cur_word(int'(cur_rd_addr)) : {16{8'hA5}};
      srch_rd_data <= srch_rd_en ? srch_word(int'(srch_rd_addr)) : {48{8'h5A}};
   end

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_mon();
      xfer_cnt = 0; rd_cnt = 0; done_cnt = 0;
      done_cycle = -1; last_cycle = -1; first_cpr_cycle = -1;
      h_cpr = 0; h_spr = 0;
   endtask

   // per-cycle observation at the falling edge
   task automatic mon();
      bit exp_srch;
      int v, c;
      @(negedge clk);
      check("port_exclusive", 160'(cpr_valid & spr_valid), 160'(0));
      if (!spr_valid) check("spr_tag_idle", 160'({spr_band, spr_col, spr_last}), 160'(0));
      if (cpr_valid && first_cpr_cycle < 0) first_cpr_cycle = cyc;
      if (h_cpr) check("cpr_hold", 160'({cpr_valid, pixel_cpr_out}), 160'({1'b1, sv_cpr}));
      if (h_spr) check("spr_hold", 160'({spr_valid, spr_band, spr_col, pixel_spr_out}),
                       160'({1'b1, sv_band, sv_col, sv_spr}));
      h_cpr = cpr_valid && !cpr_ready;
      h_spr = spr_valid && !spr_ready;
      sv_cpr = pixel_cpr_out; sv_spr = pixel_spr_out; sv_band = spr_band; sv_col = spr_col;
      if (cur_rd_en || srch_rd_en) begin
         check("rd_in_range", 160'(rd_cnt < NXFER), 160'(1));
         if (rd_cnt < 16)
            check("rd_cur", 160'({cur_rd_en, srch_rd_en, cur_rd_addr}), 160'({2'b10, rd_cnt[3:0]}));
         else
            check("rd_srch", 160'({cur_rd_en, srch_rd_en, srch_rd_addr}),
                  160'({2'b01, 6'((rd_cnt - 16) % 48)}));
         rd_cnt++;
      end
      if ((cpr_valid && cpr_ready) || (spr_valid && spr_ready)) begin
         exp_srch = (xfer_cnt >= 16);
         check("xfer_type", 160'(spr_valid), 160'(exp_srch));
         if (!exp_srch) begin
            check("cpr_data", 160'(pixel_cpr_out), 160'(cur_word(xfer_cnt)));
         end else begin
            v = (xfer_cnt - 16) / 48;
            c = (xfer_cnt - 16) % 48;
            check("spr_tag", 160'({spr_band, spr_col, spr_last}),
                  160'({5'(v), 6'(c), (xfer_cnt == NXFER - 1)}));
            check("spr_data", 160'(pixel_spr_out), 160'(exp_slice(v, c)));
            if (spr_last) last_cycle = cyc;
         end
         xfer_cnt++;
      end
      check("outstanding_le2", 160'((rd_cnt - xfer_cnt) <= 2), 160'(1));
      if (done) begin
         done_cnt++;
         done_cycle = cyc;
      end
   endtask

   // one macroblock pass; mode selects the ready/start disturbance
   task automatic run_pass(input int mode);
      int bp_left, cpr_low;
      bit bp_done;
      bp_left = 0; cpr_low = 0; bp_done = 0;
      clear_mon();
      cyc = -1;
      forever begin
         step();
         start = (cyc == 0) || (mode == 3 && cyc == 500);
         cpr_ready = 1'b1;
         spr_ready = 1'b1;
         if (mode == 2 && cpr_valid && cpr_low < 4) begin
            cpr_ready = 1'b0;
            cpr_low++;
         end
         if (mode == 1) begin
            if (bp_left > 0) begin
               spr_ready = 1'b0;
               bp_left--;
            end else if (!bp_done && spr_valid && spr_band == 5'd3 && spr_col == 6'd10) begin
               spr_ready = 1'b0;
               bp_left = 4;
               bp_done = 1;
            end
         end
         mon();
         if (mode == 1 && !spr_ready) check("bp_no_srch_rd", 160'(srch_rd_en), 160'(0));
         if (cyc == 1) check("c1_busy_rd0", 160'({busy, cur_rd_en, cur_rd_addr}), 160'({2'b11, 4'd0}));
         if (mode == 4 && xfer_cnt >= 100) return;
         if (done_cycle >= 0 && cyc > done_cycle) begin
            check("busy_after_done", 160'(busy), 160'(0));
            return;
         end
         if (cyc >= 2500) begin
            check("pass_timeout", 160'(done_cycle), 160'(1555));
            return;
         end
      end
   endtask

   task automatic finish_pass(input string name, input int exp_done);
      check({name, "_xfers"}, 160'(xfer_cnt), 160'(NXFER));
      check({name, "_done_cnt"}, 160'(done_cnt), 160'(1));
      check({name, "_done_cycle"}, 160'(done_cycle), 160'(exp_done));
      check({name, "_last_cycle"}, 160'(last_cycle), 160'(exp_done - 1));
      check({name, "_first_cpr"}, 160'(first_cpr_cycle), 160'(3));
      $display("pass %s: transfers=%0d reads=%0d done_cycle=%0d last_cycle=%0d",
               name, xfer_cnt, rd_cnt, done_cycle, last_cycle);
   endtask

   initial begin
      // reset held two cycles with start high
      clear_mon();
      step(); rst = 1'b1; start = 1'b1;
      @(negedge clk);
      step(); rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check("reset_ctrl", 160'({busy, done, cur_rd_en, srch_rd_en, cpr_valid, spr_valid, spr_last,
                               cur_rd_addr, srch_rd_addr, spr_band, spr_col}), 160'(0));
      check("reset_cpr_px", 160'(pixel_cpr_out), 160'(0));
      check("reset_spr_px", 160'(pixel_spr_out), 160'(0));
      step(); rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("post_reset_ctrl", 160'({busy, done, cur_rd_en, srch_rd_en, cpr_valid, spr_valid}), 160'(0));
      for (int i = 0; i < 3; i++) begin
         step();
         mon();
         check("idle_quiet", 160'({busy, done, cur_rd_en, srch_rd_en}), 160'(0));
      end
      $display("reset: outputs quiet, done_count=%0d", done_cnt);

      run_pass(0);
      finish_pass("full", 1555);

      run_pass(1);
      finish_pass("spr_backpressure", 1560);

      run_pass(2);
      finish_pass("cpr_backpressure", 1559);

      run_pass(3);
      for (int i = 0; i < 20; i++) begin
         step();
         mon();
      end
      check("start_busy_done_cnt", 160'(done_cnt), 160'(1));
      check("start_busy_reads", 160'(rd_cnt), 160'(NXFER));
      finish_pass("start_while_busy", 1555);

      run_pass(4);
      step(); rst = 1'b1; start = 1'b0;
      @(negedge clk);
      step(); rst = 1'b0;
      @(negedge clk);
      check("mid_reset_quiet", 160'({busy, done, cur_rd_en, srch_rd_en, cpr_valid, spr_valid}), 160'(0));
      $display("mid-stream reset after %0d transfers", xfer_cnt);
      run_pass(0);
      finish_pass("restart", 1555);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
